// File: rtl/m1_ex_issue.sv
// Operand-issue stage ahead of the M1 ALU: MEM/WB forwarding, load-use stall,
// and the single pipeline register that feeds the combinational ALU.
module m1_ex_issue #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   sys_clock_i,
  input  logic                   sys_reset_i,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  logic [4:0]             id_rs_idx_i,
  input  logic [4:0]             id_rt_idx_i,
  input  logic [31:0]            id_rs_val_i,
  input  logic [31:0]            id_rt_val_i,
  input  logic [31:0]            id_imm_i,
  input  logic                   id_use_imm_i,
  input  logic [4:0]             id_func_i,
  input  logic                   id_signed_i,
  input  logic [4:0]             id_rd_idx_i,
  input  logic                   id_wr_en_i,
  input  logic                   mem_wr_en_i,
  input  logic [4:0]             mem_rd_idx_i,
  input  logic                   mem_data_valid_i,
  input  logic [31:0]            mem_data_i,
  input  logic                   wb_wr_en_i,
  input  logic [4:0]             wb_rd_idx_i,
  input  logic [31:0]            wb_data_i,
  input  logic                   flush_i,
  input  logic                   ex_ready_i,
  output logic                   ex_valid_o,
  output logic [31:0]            alu_a_o,
  output logic [31:0]            alu_b_o,
  output logic [4:0]             alu_func_o,
  output logic                   alu_signed_o,
  output logic [4:0]             ex_rd_idx_o,
  output logic                   ex_wr_en_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic                   ex_valid_r;
  logic [31:0]            alu_a_r;
  logic [31:0]            alu_b_r;
  logic [4:0]             alu_func_r;
  logic                   alu_signed_r;
  logic [4:0]             ex_rd_idx_r;
  logic                   ex_wr_en_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic        rs_mem_hit_s;
  logic        rs_wb_hit_s;
  logic        rt_mem_hit_s;
  logic        rt_wb_hit_s;
  logic        hazard_s;
  logic        free_s;
  logic        ready_s;
  logic        load_s;
  logic        stall_inc_s;
  logic [31:0] rs_fwd_s;
  logic [31:0] rt_fwd_s;
  logic [31:0] opb_s;

  // A pending MEM match keeps the register-file value; the stall makes it irrelevant
  // and WB must not win over a younger in-flight producer.
  function automatic logic [31:0] fwd_sel(
    input logic        mem_hit,
    input logic        mem_ok,
    input logic        wb_hit,
    input logic [31:0] mem_d,
    input logic [31:0] wb_d,
    input logic [31:0] rf_d
  );
    logic [31:0] res;
    if (mem_hit) begin
      if (mem_ok) begin
        res = mem_d;
      end else begin
        res = rf_d;
      end
    end else if (wb_hit) begin
      res = wb_d;
    end else begin
      res = rf_d;
    end
    return res;
  endfunction

  // Source matching against the MEM and WB destinations (r0 never forwards).
  always_comb begin
    rs_mem_hit_s = (id_rs_idx_i != 5'd0) && mem_wr_en_i && (mem_rd_idx_i == id_rs_idx_i);
    rs_wb_hit_s  = (id_rs_idx_i != 5'd0) && wb_wr_en_i  && (wb_rd_idx_i  == id_rs_idx_i);
    rt_mem_hit_s = !id_use_imm_i && (id_rt_idx_i != 5'd0) && mem_wr_en_i &&
                   (mem_rd_idx_i == id_rt_idx_i);
    rt_wb_hit_s  = !id_use_imm_i && (id_rt_idx_i != 5'd0) && wb_wr_en_i &&
                   (wb_rd_idx_i == id_rt_idx_i);
  end

  // Operand resolution, hazard detection and handshake.
  always_comb begin
    rs_fwd_s = fwd_sel(rs_mem_hit_s, mem_data_valid_i, rs_wb_hit_s,
                       mem_data_i, wb_data_i, id_rs_val_i);
    rt_fwd_s = fwd_sel(rt_mem_hit_s, mem_data_valid_i, rt_wb_hit_s,
                       mem_data_i, wb_data_i, id_rt_val_i);
    if (id_use_imm_i) begin
      opb_s = id_imm_i;
    end else begin
      opb_s = rt_fwd_s;
    end
    hazard_s    = id_valid_i && !mem_data_valid_i && (rs_mem_hit_s || rt_mem_hit_s);
    free_s      = !ex_valid_r || ex_ready_i;
    ready_s     = !sys_reset_i && (flush_i || (free_s && !hazard_s));
    load_s      = id_valid_i && ready_s && !flush_i;
    stall_inc_s = id_valid_i && hazard_s && !flush_i;
  end

  // Issue register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      ex_valid_r   <= 1'b0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_func_r   <= 5'd0;
      alu_signed_r <= 1'b0;
      ex_rd_idx_r  <= 5'd0;
      ex_wr_en_r   <= 1'b0;
    end else if (flush_i) begin
      ex_valid_r <= 1'b0;
    end else if (load_s) begin
      ex_valid_r   <= 1'b1;
      alu_a_r      <= rs_fwd_s;
      alu_b_r      <= opb_s;
      alu_func_r   <= id_func_i;
      alu_signed_r <= id_signed_i;
      ex_rd_idx_r  <= id_rd_idx_i;
      ex_wr_en_r   <= id_wr_en_i;
    end else if (ex_ready_i) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (stall_inc_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign id_ready_o   = ready_s;
  assign ex_valid_o   = ex_valid_r;
  assign alu_a_o      = alu_a_r;
  assign alu_b_o      = alu_b_r;
  assign alu_func_o   = alu_func_r;
  assign alu_signed_o = alu_signed_r;
  assign ex_rd_idx_o  = ex_rd_idx_r;
  assign ex_wr_en_o   = ex_wr_en_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_m1_ex_issue.sv
// Directed bench for m1_ex_issue: expected issue-register contents are queued
// when an instruction is offered and compared one cycle later.
module tb_m1_ex_issue;

  localparam int CW = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  func;
    logic        sgn;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          id_valid, id_ready;
  logic [4:0]    rs_idx, rt_idx, rd_idx, func;
  logic [31:0]   rs_val, rt_val, imm;
  logic          use_imm, sgn, wr_en;
  logic          mem_we, mem_dv, wb_we;
  logic [4:0]    mem_rd, wb_rd;
  logic [31:0]   mem_d, wb_d;
  logic          flush, ex_ready;
  logic          ex_valid;
  logic [31:0]   alu_a, alu_b;
  logic [4:0]    alu_func, ex_rd;
  logic          alu_sgn, ex_we;
  logic [CW-1:0] stall_cnt;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  exp_t sb[$];
  exp_t last;

  m1_ex_issue #(.STALL_CNT_W(CW)) dut (
    .sys_clock_i(clk), .sys_reset_i(rst),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_rs_idx_i(rs_idx), .id_rt_idx_i(rt_idx),
    .id_rs_val_i(rs_val), .id_rt_val_i(rt_val),
    .id_imm_i(imm), .id_use_imm_i(use_imm),
    .id_func_i(func), .id_signed_i(sgn),
    .id_rd_idx_i(rd_idx), .id_wr_en_i(wr_en),
    .mem_wr_en_i(mem_we), .mem_rd_idx_i(mem_rd),
    .mem_data_valid_i(mem_dv), .mem_data_i(mem_d),
    .wb_wr_en_i(wb_we), .wb_rd_idx_i(wb_rd), .wb_data_i(wb_d),
    .flush_i(flush), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_func_o(alu_func), .alu_signed_o(alu_sgn),
    .ex_rd_idx_o(ex_rd), .ex_wr_en_o(ex_we),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                              input logic s, input logic [4:0] rd, input logic we);
    exp_t e;
    e.a = a; e.b = b; e.func = f; e.sgn = s; e.rd = rd; e.we = we;
    return e;
  endfunction

  task automatic set_id(input logic [4:0] rs, input logic [31:0] rsv, input logic [4:0] rt,
                        input logic [31:0] rtv, input logic [31:0] im, input logic ui,
                        input logic [4:0] f, input logic s, input logic [4:0] rd, input logic we);
    id_valid = 1'b1;
    rs_idx = rs; rs_val = rsv; rt_idx = rt; rt_val = rtv;
    imm = im; use_imm = ui; func = f; sgn = s; rd_idx = rd; wr_en = we;
  endtask

  task automatic chk_regs(input string tag, input exp_t e);
    chk({tag, "/a"},    alu_a, e.a);
    chk({tag, "/b"},    alu_b, e.b);
    chk({tag, "/func"}, 32'(alu_func), 32'(e.func));
    chk({tag, "/sgn"},  32'(alu_sgn), 32'(e.sgn));
    chk({tag, "/rd"},   32'(ex_rd), 32'(e.rd));
    chk({tag, "/we"},   32'(ex_we), 32'(e.we));
  endtask

  // One cycle from a negedge: check ready, optionally queue, clock, compare.
  task automatic cyc(input string tag, input logic exp_rdy, input logic push,
                     input exp_t e, input logic exp_v);
    exp_t cur;
    #1;
    chk({tag, "/ready"}, 32'(id_ready), 32'(exp_rdy));
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      cur  = sb.pop_front();
      last = cur;
      chk({tag, "/valid"}, 32'(ex_valid), 32'd1);
      chk_regs(tag, cur);
    end else begin
      chk({tag, "/valid"}, 32'(ex_valid), 32'(exp_v));
      if (exp_v) chk_regs({tag, "/stable"}, last);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    mem_we = 1'b0; mem_dv = 1'b1; mem_rd = 5'd0; mem_d = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_d = 32'd0;
    set_id(5'd3, 32'h10, 5'd4, 32'h20, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    last = mk(32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Reset with an instruction offered: no acceptance, all state zero.
    @(negedge clk);
    #1;
    chk("rst/ready", 32'(id_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst/valid", 32'(ex_valid), 32'd0);
    chk("rst/stall", 32'(stall_cnt), 32'd0);
    chk_regs("rst", last);
    @(negedge clk);
    rst = 1'b0;

    // Plain ADD, then MEM / WB / r0 forwarding back-to-back.
    cyc("add", 1'b1, 1'b1, mk(32'h10, 32'h20, 5'd0, 1'b0, 5'd9, 1'b1), 1'b1);
    set_id(5'd5, 32'h55, 5'd4, 32'h20, 32'd0, 1'b0, 5'd3, 1'b1, 5'd10, 1'b1);
    mem_we = 1'b1; mem_rd = 5'd5; mem_dv = 1'b1; mem_d = 32'hAAAA;
    wb_we = 1'b1; wb_rd = 5'd5; wb_d = 32'hBBBB;
    cyc("fwd_mem", 1'b1, 1'b1, mk(32'hAAAA, 32'h20, 5'd3, 1'b1, 5'd10, 1'b1), 1'b1);
    mem_we = 1'b0;
    cyc("fwd_wb", 1'b1, 1'b1, mk(32'hBBBB, 32'h20, 5'd3, 1'b1, 5'd10, 1'b1), 1'b1);
    set_id(5'd0, 32'h77, 5'd4, 32'h20, 32'd0, 1'b0, 5'd1, 1'b0, 5'd11, 1'b0);
    mem_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    cyc("r0", 1'b1, 1'b1, mk(32'h77, 32'h20, 5'd1, 1'b0, 5'd11, 1'b0), 1'b1);
    set_id(5'd3, 32'h10, 5'd6, 32'h66, 32'd0, 1'b0, 5'd2, 1'b0, 5'd12, 1'b1);
    mem_rd = 5'd6; mem_d = 32'hC0DE; wb_rd = 5'd6;
    cyc("fwd_rt", 1'b1, 1'b1, mk(32'h10, 32'hC0DE, 5'd2, 1'b0, 5'd12, 1'b1), 1'b1);

    // Load-use: MEM r7 pending stalls rs=7, counter saturates at 3.
    wb_we = 1'b0;
    mem_rd = 5'd7; mem_dv = 1'b0; mem_d = 32'hDEAD;
    set_id(5'd7, 32'h70, 5'd4, 32'h20, 32'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
    for (int i = 0; i < 3; i++) cyc("ldu", 1'b0, 1'b0, last, 1'b0);
    chk("ldu/stall3", 32'(stall_cnt), 32'd3);
    cyc("ldu_sat", 1'b0, 1'b0, last, 1'b0);
    chk("ldu/stall_sat", 32'(stall_cnt), 32'd3);
    mem_dv = 1'b1; mem_d = 32'h1234;
    cyc("ldu_go", 1'b1, 1'b1, mk(32'h1234, 32'h20, 5'd0, 1'b0, 5'd13, 1'b1), 1'b1);

    // Immediate operand hides a pending rt.
    mem_dv = 1'b0;
    set_id(5'd3, 32'h10, 5'd7, 32'h70, 32'hFFFF_FFFC, 1'b1, 5'd4, 1'b1, 5'd14, 1'b1);
    cyc("imm", 1'b1, 1'b1, mk(32'h10, 32'hFFFF_FFFC, 5'd4, 1'b1, 5'd14, 1'b1), 1'b1);

    // Backpressure holds the register, then the waiting instruction loads.
    mem_we = 1'b0; ex_ready = 1'b0;
    set_id(5'd3, 32'h10, 5'd4, 32'h20, 32'd0, 1'b0, 5'd7, 1'b0, 5'd15, 1'b1);
    cyc("hold1", 1'b0, 1'b0, last, 1'b1);
    cyc("hold2", 1'b0, 1'b0, last, 1'b1);
    ex_ready = 1'b1;
    cyc("resume", 1'b1, 1'b1, mk(32'h10, 32'h20, 5'd7, 1'b0, 5'd15, 1'b1), 1'b1);

    // Flush with a hazard and backpressure: acknowledged, discarded, valid drops.
    ex_ready = 1'b0; flush = 1'b1;
    mem_we = 1'b1; mem_rd = 5'd7; mem_dv = 1'b0;
    set_id(5'd7, 32'h70, 5'd4, 32'h20, 32'd0, 1'b0, 5'd5, 1'b0, 5'd16, 1'b1);
    cyc("flush", 1'b1, 1'b0, last, 1'b0);
    flush = 1'b0; mem_we = 1'b0; ex_ready = 1'b1;
    set_id(5'd3, 32'h10, 5'd4, 32'h20, 32'd0, 1'b0, 5'd6, 1'b1, 5'd17, 1'b0);
    cyc("post_flush", 1'b1, 1'b1, mk(32'h10, 32'h20, 5'd6, 1'b1, 5'd17, 1'b0), 1'b1);

    // Reset while the register is held.
    ex_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rst2/ready", 32'(id_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst2/valid", 32'(ex_valid), 32'd0);
    chk("rst2/stall", 32'(stall_cnt), 32'd0);
    chk_regs("rst2", mk(32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    cyc("idle", 1'b1, 1'b0, last, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/m1_ex_issue.md
Name: m1_ex_issue

Overview:
Operand-issue stage directly upstream of the M1 ALU. It accepts decoded instructions from the decode stage over a valid/ready handshake and resolves operands by forwarding from the MEM and WB stages. It stalls on load-use hazards and registers the ALU inputs (operand A, operand B, function, signed flag) plus destination info into one pipeline register that feeds the combinational ALU. A saturating stall counter is provided for performance debug.

Parameters:
STALL_CNT_W, 16, width of the saturating hazard-stall counter

Ports:
sys_clock_i  in  1  core clock, all state updates on rising edge
sys_reset_i  in  1  synchronous, active-high reset
id_valid_i  in  1  decode presents an instruction
id_ready_o  out  1  stage accepts the instruction this cycle
id_rs_idx_i  in  5  source register A index
id_rt_idx_i  in  5  source register B index
id_rs_val_i  in  32  register-file value for rs
id_rt_val_i  in  32  register-file value for rt
id_imm_i  in  32  extended immediate
id_use_imm_i  in  1  operand B is the immediate, not rt
id_func_i  in  5  ALU function code, passed through unchanged
id_signed_i  in  1  signed operation flag
id_rd_idx_i  in  5  destination register index
id_wr_en_i  in  1  instruction writes rd
mem_wr_en_i  in  1  MEM stage will write mem_rd_idx_i
mem_rd_idx_i  in  5  MEM stage destination
mem_data_valid_i  in  1  mem_data_i is final (0 = load still pending)
mem_data_i  in  32  MEM stage result
wb_wr_en_i  in  1  WB stage writes wb_rd_idx_i
wb_rd_idx_i  in  5  WB stage destination
wb_data_i  in  32  WB stage result
flush_i  in  1  discard the issue register and any incoming instruction
ex_ready_i  in  1  downstream EX/MEM consumes ex_valid_o
ex_valid_o  out  1  issue register holds a valid instruction
alu_a_o  out  32  registered operand A to ALU
alu_b_o  out  32  registered operand B to ALU
alu_func_o  out  5  registered ALU function
alu_signed_o  out  1  registered signed flag
ex_rd_idx_o  out  5  registered destination index
ex_wr_en_o  out  1  registered write enable
stall_cnt_o  out  STALL_CNT_W  hazard-stall cycles, saturating

Behaviour:
- Reset (sys_reset_i=1 at clock edge): ex_valid_o, alu_a_o, alu_b_o, alu_func_o, alu_signed_o, ex_rd_idx_o, ex_wr_en_o and stall_cnt_o all 0. id_ready_o is forced 0 while sys_reset_i=1. Reset mid-transfer drops the instruction.
- Forwarding per source (rs; rt only when id_use_imm_i=0). Index 0 is never forwarded and uses the register-file value. Priority: MEM match (mem_wr_en_i, equal index, mem_data_valid_i=1) gives mem_data_i; otherwise WB match gives wb_data_i; otherwise the id_*_val_i value.
- Hazard: id_valid_i=1 and a used, nonzero source matches the MEM destination with mem_wr_en_i=1 and mem_data_valid_i=0. A MEM match with pending data never falls through to WB.
- Slot free: free = ~ex_valid_o | ex_ready_i.
- id_ready_o = ~sys_reset_i & (flush_i | (free & ~hazard)). This is combinational, with no dependency on id_valid_i.
- Load: id_valid_i & id_ready_o & ~flush_i. The register captures the resolved A, B (immediate if id_use_imm_i), func, signed, rd and wr_en, and ex_valid_o=1 next cycle. Latency is 1 cycle from accept to ALU inputs.
- Hold: ex_valid_o=1 & ex_ready_i=0 leaves all outputs stable.
- Drain: ex_ready_i=1 with no load gives ex_valid_o=0 next cycle. Data outputs keep their last values.
- flush_i dominates: next cycle ex_valid_o=0. An incoming instruction is acknowledged (id_ready_o=1) and discarded. Hazard and ex_ready_i are ignored.
- stall_cnt_o increments by 1 each cycle with id_valid_i & hazard & ~flush_i. It holds at all-ones.
- Back-to-back: with ex_ready_i=1 continuously, one instruction is issued per cycle and no bubbles are added.

Test Plan:
- Reset, then issue rs=3 (val 0x10), rt=4 (val 0x20), func ADD, no forwarding -> next cycle ex_valid_o=1, alu_a_o=0x10, alu_b_o=0x20, alu_func_o=ADD.
- Issue with rs=5 while MEM writes r5=0xAAAA (valid) and WB writes r5=0xBBBB -> alu_a_o=0xAAAA. Repeat with MEM wr_en=0 -> 0xBBBB. Repeat with rs=0 and both writing r0 -> id_rs_val_i used.
- Load-use: MEM r7 pending (mem_data_valid_i=0), rs=7 for 3 cycles, then valid=1 with data 0x1234 -> id_ready_o=0 for 3 cycles, stall_cnt_o=3, then accept with alu_a_o=0x1234.
- id_use_imm_i=1, imm=0xFFFFFFFC, rt=7 pending in MEM -> no stall, alu_b_o=0xFFFFFFFC.
- ex_ready_i=0 for 2 cycles with id_valid_i=1 -> outputs stable, id_ready_o=0. Then ex_ready_i=1 -> new instruction loaded the next cycle.
- flush_i together with id_valid_i while ex_valid_o=1 -> id_ready_o=1, next cycle ex_valid_o=0. Then assert reset mid-hold -> all outputs 0.
